// File: rtl/scarv_soc_reset_seq.sv
// SoC reset sequencer: releases NDOMAINS active-low domain resets in index order after PLL lock,
// with per-domain software resets, a global software re-sequence and lock-loss recovery.
module scarv_soc_reset_seq #(
  parameter int unsigned NDOMAINS                       = 4,
  parameter int unsigned CNT_W                          = 8,
  parameter int unsigned BASE_CYCLES                    = 16,
  parameter logic [NDOMAINS*CNT_W-1:0] DOMAIN_CYCLES    = {NDOMAINS{8'd16}},
  parameter int unsigned SYNC_STAGES                    = 2,
  localparam int unsigned DOM_W = (NDOMAINS > 1) ? $clog2(NDOMAINS) : 1
) (
  input  logic                f_clk,
  input  logic                sys_reset,
  input  logic                f_clk_locked,
  input  logic [NDOMAINS-1:0] sw_req,
  input  logic                sw_req_all,
  output logic [NDOMAINS-1:0] resetn,
  output logic                ready,
  output logic [1:0]          cause,
  output logic [DOM_W-1:0]    cause_dom
);

  localparam int unsigned SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [1:0] CauseExt  = 2'd0;
  localparam logic [1:0] CauseLock = 2'd1;
  localparam logic [1:0] CauseDom  = 2'd2;
  localparam logic [1:0] CauseAll  = 2'd3;

  // Terminal counter values; a programmed length of 0 behaves as 1.
  localparam logic [CNT_W-1:0] BASE_LAST =
      (BASE_CYCLES == 0) ? '0 : CNT_W'(BASE_CYCLES - 1);
  localparam logic [DOM_W-1:0] LAST_DOM = DOM_W'(NDOMAINS - 1);

  typedef enum logic [2:0] {
    StWaitLock,
    StBase,
    StSeq,
    StRun,
    StSoft
  } state_e;

  state_e               state_q, state_d;
  logic [SS-1:0]        sync_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DOM_W-1:0]     idx_q, idx_d;
  logic [NDOMAINS-1:0]  pending_q, pending_d;
  logic [NDOMAINS-1:0]  resetn_q, resetn_d;
  logic                 ready_q, ready_d;
  logic [1:0]           cause_q, cause_d;
  logic [DOM_W-1:0]     cause_dom_q, cause_dom_d;

  logic                 lock_s;
  logic [NDOMAINS-1:0]  pend_eff;
  logic [NDOMAINS-1:0]  k_mask;
  logic [DOM_W-1:0]     sel;

  assign lock_s = sync_q[SS-1];

  function automatic logic [CNT_W-1:0] dom_last(input int unsigned i);
    logic [CNT_W-1:0] v;
    v = DOMAIN_CYCLES[i*CNT_W +: CNT_W];
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  always_ff @(posedge f_clk or posedge sys_reset) begin
    if (sys_reset) begin
      sync_q      <= '0;
      state_q     <= StWaitLock;
      cnt_q       <= '0;
      idx_q       <= '0;
      pending_q   <= '0;
      resetn_q    <= '0;
      ready_q     <= 1'b0;
      cause_q     <= CauseExt;
      cause_dom_q <= '0;
    end else begin
      sync_q      <= {sync_q[SS-2:0], f_clk_locked};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pending_q   <= pending_d;
      resetn_q    <= resetn_d;
      ready_q     <= ready_d;
      cause_q     <= cause_d;
      cause_dom_q <= cause_dom_d;
    end
  end

  always_comb begin
    pend_eff = pending_q | sw_req;
    k_mask = '0;
    k_mask[idx_q] = 1'b1;
    sel = '0;
    for (int i = int'(NDOMAINS) - 1; i >= 0; i--) begin
      if (pend_eff[i]) sel = DOM_W'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    pending_d   = pending_q;
    resetn_d    = resetn_q;
    ready_d     = ready_q;
    cause_d     = cause_q;
    cause_dom_d = cause_dom_q;

    unique case (state_q)
      StWaitLock: begin
        cnt_d    = '0;
        resetn_d = '0;
        ready_d  = 1'b0;
        if (lock_s) state_d = StBase;
      end
      StBase: begin
        if (cnt_q == BASE_LAST) begin
          state_d = StSeq;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      StSeq: begin
        if (cnt_q == dom_last(int'(idx_q))) begin
          resetn_d[idx_q] = 1'b1;
          cnt_d           = '0;
          if (idx_q == LAST_DOM) begin
            state_d = StRun;
            ready_d = 1'b1;
          end else begin
            idx_d = idx_q + DOM_W'(1);
          end
        end
      end
      StRun: begin
        cnt_d     = '0;
        pending_d = pend_eff;
        if (pend_eff != '0) begin
          state_d       = StSoft;
          idx_d         = sel;
          resetn_d[sel] = 1'b0;
          ready_d       = 1'b0;
          cause_d       = CauseDom;
          cause_dom_d   = sel;
        end
      end
      StSoft: begin
        // Requests for the domain already in reset are absorbed.
        pending_d = pend_eff & ~k_mask;
        if (cnt_q == dom_last(int'(idx_q))) begin
          resetn_d[idx_q] = 1'b1;
          state_d         = StRun;
          cnt_d           = '0;
          ready_d         = (pending_d == '0);
        end
      end
      default: begin
        state_d = StWaitLock;
      end
    endcase

    if ((state_q == StRun || state_q == StSoft) && sw_req_all) begin
      state_d     = StBase;
      cnt_d       = '0;
      pending_d   = '0;
      resetn_d    = '0;
      ready_d     = 1'b0;
      cause_d     = CauseAll;
      cause_dom_d = '0;
    end

    if (state_q != StWaitLock && !lock_s) begin
      state_d     = StWaitLock;
      cnt_d       = '0;
      pending_d   = '0;
      resetn_d    = '0;
      ready_d     = 1'b0;
      cause_d     = CauseLock;
      cause_dom_d = '0;
    end
  end

  assign resetn    = resetn_q;
  assign ready     = ready_q;
  assign cause     = cause_q;
  assign cause_dom = cause_dom_q;

endmodule

// File: tb/tb_scarv_soc_reset_seq.sv
// Bench for scarv_soc_reset_seq: directed vector table, async reset sequence and random stimulus
// checked against an edge-timeline reference model.
module tb_scarv_soc_reset_seq;

  localparam int NDOM = 4;
  localparam int BASE = 16;
  localparam int DCYC = 16;

  logic        f_clk;
  logic        sys_reset;
  logic        f_clk_locked;
  logic [3:0]  sw_req;
  logic        sw_req_all;
  logic [3:0]  resetn;
  logic        ready;
  logic [1:0]  cause;
  logic [1:0]  cause_dom;

  scarv_soc_reset_seq dut (
    .f_clk        (f_clk),
    .sys_reset    (sys_reset),
    .f_clk_locked (f_clk_locked),
    .sw_req       (sw_req),
    .sw_req_all   (sw_req_all),
    .resetn       (resetn),
    .ready        (ready),
    .cause        (cause),
    .cause_dom    (cause_dom)
  );

  initial f_clk = 1'b0;
  always #5 f_clk = ~f_clk;

  int nchk  = 0;
  int nfail = 0;
  int n     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: release edges come from E0 plus cumulative hold lengths.
  localparam int MW = 0, MQ = 1, MR = 2, MS = 3;
  int         m_mode  = MW;
  int         m_n     = 0;
  int         m_e0    = 0;
  int         m_s     = 0;
  int         m_k     = 0;
  logic [3:0] m_pend  = '0;
  logic [1:0] lk      = '0;
  logic [3:0] m_rn    = '0;
  logic       m_rdy   = 1'b0;
  logic [1:0] m_cause = '0;
  logic [1:0] m_dom   = '0;
  int         ps[NDOM];

  initial begin
    int acc = 0;
    for (int i = 0; i < NDOM; i++) begin
      acc += DCYC;
      ps[i] = acc;
    end
  end

  task automatic model_step();
    logic       ls;
    logic [3:0] eff;
    if (sys_reset) begin
      m_mode = MW; m_pend = '0; lk = '0; m_cause = 2'd0; m_dom = 2'd0; m_n = 0;
    end else begin
      m_n++;
      ls = lk[1];
      if (m_mode != MW && !ls) begin
        m_mode = MW; m_pend = '0; m_cause = 2'd1; m_dom = 2'd0;
      end else if ((m_mode == MR || m_mode == MS) && sw_req_all) begin
        m_mode = MQ; m_e0 = m_n; m_pend = '0; m_cause = 2'd3; m_dom = 2'd0;
      end else begin
        case (m_mode)
          MW: if (ls) begin m_mode = MQ; m_e0 = m_n; end
          MQ: if (m_n == m_e0 + BASE + ps[NDOM-1]) m_mode = MR;
          MR: begin
            eff = m_pend | sw_req;
            if (eff != 0) begin
              for (int i = NDOM - 1; i >= 0; i--) if (eff[i]) m_k = i;
              m_mode = MS; m_s = m_n; m_pend = eff; m_cause = 2'd2; m_dom = 2'(m_k);
            end
          end
          default: begin
            m_pend = (m_pend | sw_req) & ~(4'b0001 << m_k);
            if (m_n == m_s + DCYC) m_mode = MR;
          end
        endcase
      end
      lk = {lk[0], f_clk_locked};
    end
    case (m_mode)
      MW: begin m_rn = '0; m_rdy = 1'b0; end
      MQ: begin
        for (int i = 0; i < NDOM; i++) m_rn[i] = (m_n >= m_e0 + BASE + ps[i]);
        m_rdy = 1'b0;
      end
      MR: begin m_rn = 4'hf; m_rdy = (m_pend == 0); end
      default: begin m_rn = 4'hf; m_rn[m_k] = 1'b0; m_rdy = 1'b0; end
    endcase
  endtask

  initial begin
    forever begin
      @(posedge f_clk or posedge sys_reset);
      model_step();
    end
  end

  task automatic tick();
    @(posedge f_clk);
    #1;
    n++;
    chk("model resetn", 32'(resetn), 32'(m_rn));
    chk("model ready", 32'(ready), 32'(m_rdy));
    chk("model cause", 32'(cause), 32'(m_cause));
    chk("model cause_dom", 32'(cause_dom), 32'(m_dom));
  endtask

  typedef struct {
    int         edge_n;
    logic [3:0] req;
    logic       all;
    logic       lock;
    logic [3:0] rn;
    logic       rdy;
    logic [1:0] cs;
    logic [1:0] dm;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int e, input logic [3:0] rq, input logic al, input logic lo,
                              input logic [3:0] rn, input logic rd, input logic [1:0] cs,
                              input logic [1:0] dm);
    vec_t v;
    v.edge_n = e; v.req = rq; v.all = al; v.lock = lo;
    v.rn = rn; v.rdy = rd; v.cs = cs; v.dm = dm;
    tbl.push_back(v);
  endfunction

  initial begin
    int e;
    int low;

    // Boot with lock already present; E0 = edge 3.
    add(3,   4'b0000, 0, 1, 4'b0000, 0, 0, 0);
    add(34,  4'b0000, 0, 1, 4'b0000, 0, 0, 0);
    add(35,  4'b0000, 0, 1, 4'b0001, 0, 0, 0);
    add(51,  4'b0000, 0, 1, 4'b0011, 0, 0, 0);
    add(67,  4'b0000, 0, 1, 4'b0111, 0, 0, 0);
    add(82,  4'b0000, 0, 1, 4'b0111, 0, 0, 0);
    add(83,  4'b0000, 0, 1, 4'b1111, 1, 0, 0);
    // Single domain software reset.
    add(90,  4'b0100, 0, 1, 4'b1011, 0, 2, 2);
    add(105, 4'b0000, 0, 1, 4'b1011, 0, 2, 2);
    add(106, 4'b0000, 0, 1, 4'b1111, 1, 2, 2);
    // Two simultaneous requests serviced lowest index first.
    add(110, 4'b1010, 0, 1, 4'b1101, 0, 2, 1);
    add(125, 4'b0000, 0, 1, 4'b1101, 0, 2, 1);
    add(126, 4'b0000, 0, 1, 4'b1111, 0, 2, 1);
    add(127, 4'b0000, 0, 1, 4'b0111, 0, 2, 3);
    add(142, 4'b0000, 0, 1, 4'b0111, 0, 2, 3);
    add(143, 4'b0000, 0, 1, 4'b1111, 1, 2, 3);
    // Global request during a domain reset.
    add(150, 4'b0010, 0, 1, 4'b1101, 0, 2, 1);
    add(155, 4'b0000, 1, 1, 4'b0000, 0, 3, 0);
    add(186, 4'b0000, 0, 1, 4'b0000, 0, 3, 0);
    add(187, 4'b0000, 0, 1, 4'b0001, 0, 3, 0);
    add(235, 4'b0000, 0, 1, 4'b1111, 1, 3, 0);
    // Lock loss during sequencing, then relock.
    add(240, 4'b0000, 1, 1, 4'b0000, 0, 3, 0);
    add(272, 4'b0000, 0, 1, 4'b0001, 0, 3, 0);
    add(280, 4'b0000, 0, 0, 4'b0001, 0, 3, 0);
    add(281, 4'b0000, 0, 0, 4'b0001, 0, 3, 0);
    add(282, 4'b0000, 0, 0, 4'b0000, 0, 1, 0);
    add(290, 4'b0000, 0, 1, 4'b0000, 0, 1, 0);
    add(323, 4'b0000, 0, 1, 4'b0000, 0, 1, 0);
    add(324, 4'b0000, 0, 1, 4'b0001, 0, 1, 0);
    add(372, 4'b0000, 0, 1, 4'b1111, 1, 1, 0);

    sys_reset = 1'b1; f_clk_locked = 1'b1; sw_req = '0; sw_req_all = 1'b0;
    repeat (2) tick();
    chk("reset resetn", 32'(resetn), 32'h0);
    chk("reset ready", 32'(ready), 32'h0);
    chk("reset cause", 32'(cause), 32'h0);
    chk("reset cause_dom", 32'(cause_dom), 32'h0);
    sys_reset = 1'b0;
    n = 0;

    foreach (tbl[r]) begin
      while (n < tbl[r].edge_n - 1) tick();
      sw_req = tbl[r].req; sw_req_all = tbl[r].all; f_clk_locked = tbl[r].lock;
      tick();
      sw_req = '0; sw_req_all = 1'b0;
      chk($sformatf("vec%0d@%0d resetn", r, tbl[r].edge_n), 32'(resetn), 32'(tbl[r].rn));
      chk($sformatf("vec%0d@%0d ready", r, tbl[r].edge_n), 32'(ready), 32'(tbl[r].rdy));
      chk($sformatf("vec%0d@%0d cause", r, tbl[r].edge_n), 32'(cause), 32'(tbl[r].cs));
      chk($sformatf("vec%0d@%0d cause_dom", r, tbl[r].edge_n), 32'(cause_dom), 32'(tbl[r].dm));
    end

    // Asynchronous reset in the middle of a domain software reset.
    while (n < 379) tick();
    sw_req = 4'b0001;
    tick();
    sw_req = '0;
    chk("soft0 resetn", 32'(resetn), 32'he);
    repeat (3) tick();
    #2 sys_reset = 1'b1;
    #1;
    chk("async resetn", 32'(resetn), 32'h0);
    chk("async ready", 32'(ready), 32'h0);
    chk("async cause", 32'(cause), 32'h0);
    chk("async cause_dom", 32'(cause_dom), 32'h0);
    tick();
    sys_reset = 1'b0;
    e = 0;
    while (!ready && e < 200) begin
      tick();
      e++;
    end
    chk("reboot ready latency", 32'(e), 32'd83);
    chk("reboot cause", 32'(cause), 32'h0);
    chk("reboot resetn", 32'(resetn), 32'hf);

    // Random phase against the reference model.
    low = 0;
    for (int c = 0; c < 5000; c++) begin
      if (low > 0) begin
        f_clk_locked = 1'b0;
        low--;
      end else begin
        f_clk_locked = 1'b1;
        if ($urandom_range(0, 399) == 0) low = $urandom_range(1, 8);
      end
      sw_req     = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      sw_req_all = ($urandom_range(0, 149) == 0);
      tick();
    end
    sw_req = '0; sw_req_all = 1'b0; f_clk_locked = 1'b1;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
